// File: rtl/daq_edge_src.sv
// -----------------------------------------------------------------------------
// daq_edge_src
//   Upstream DAQ channel. Synchronises NCH asynchronous logic inputs, stamps
//   every change of the synchronised input vector with systime[23:0], buffers
//   the events in a local FIFO and ships them as packets through one
//   req/grant/valid/end slot of the DAQ arbiter. Events that find the FIFO
//   full are dropped and counted; the count travels in the next header.
//
//   Packet: header {TAG, n[7:0], drops[15:0]} followed by n event words
//   {8'(input state), systime[23:0]}, all words back-to-back, daq_end on the
//   last one. n is frozen at grant time.
//
//   rst must only be asserted together with the system reset: the arbiter
//   keeps no state of its own about this slot.
//
// Ports
//   clk        in   1     system clock
//   rst        in   1     synchronous reset, active high
//   systime    in   32    free-running system time (bits 23:0 are stored)
//   enable     in   1     1 = capture input changes
//   sig_in     in   NCH   asynchronous inputs
//   daq_req    out  1     request to arbiter
//   daq_grant  in   1     one-cycle grant pulse from arbiter
//   daq_valid  out  1     daq_data holds a packet word
//   daq_end    out  1     last word of packet
//   daq_data   out  32    packet word
// -----------------------------------------------------------------------------
module daq_edge_src #(
  parameter int         NCH        = 4,
  parameter logic [7:0] TAG        = 8'hE1,
  parameter int         FIFO_DEPTH = 64,
  parameter int         BURST      = 16,
  parameter int         MAX_EVENTS = 32,
  parameter int         TIMEOUT    = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     systime,
  input  logic            enable,
  input  logic [NCH-1:0]  sig_in,
  output logic            daq_req,
  input  logic            daq_grant,
  output logic            daq_valid,
  output logic            daq_end,
  output logic [31:0]     daq_data
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW      = AW + 1;
  localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_TRIG = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HDR,
    S_DATA
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [TW-1:0] sat_inc_tmr(input logic [TW-1:0] v);
    return (v == TMR_MAX) ? v : v + TW'(1);
  endfunction

  // Input synchroniser and change detector
  logic [NCH-1:0] r_sync_p0;
  logic [NCH-1:0] r_sync_p1;
  logic [NCH-1:0] r_prev_p2;

  // Event FIFO
  logic [31:0]    r_mem [0:(1<<AW)-1];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;

  // Drop counter and request timer
  logic [15:0]    r_drops;
  logic [TW-1:0]  r_timer;

  // Packet FSM and registered outputs
  state_t         r_state;
  logic           r_req;
  logic           r_valid;
  logic           r_end;
  logic [31:0]    r_data;
  logic [7:0]     r_n;
  logic [7:0]     r_rem;

  state_t         w_state_nxt;
  logic           w_req_nxt;
  logic           w_valid_nxt;
  logic           w_end_nxt;
  logic [31:0]    w_data_nxt;
  logic [7:0]     w_n_nxt;
  logic [7:0]     w_rem_nxt;
  logic           w_grant_take;
  logic           w_pop;

  logic           w_change;
  logic           w_push_req;
  logic           w_full;
  logic           w_push;
  logic           w_drop;
  logic [31:0]    w_push_word;
  logic [31:0]    w_rd_word;
  logic [7:0]     w_n_grant;
  logic           w_timeout;
  logic           w_unused_ok;

  // Only the low 24 bits of systime are stored in an event word.
  assign w_unused_ok = ^systime[31:24];

  // ---- stage p0/p1: two-FF synchroniser, p2: previous synced value ----
  // These keep tracking while enable=0, so re-enabling cannot see a stale
  // difference and invent an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_prev_p2 <= '0;
    end else begin
      r_sync_p0 <= sig_in;
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  assign w_change    = (r_sync_p1 != r_prev_p2);
  assign w_push_req  = enable && w_change;
  assign w_push_word = {8'(r_sync_p1), systime[23:0]};

  // ---- FIFO ----
  // A pop in the same cycle frees the slot, so a full FIFO with a pop still
  // accepts the push.
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && w_full && !w_pop;
  assign w_rd_word = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ---- drop counter ----
  // The header takes the count as it stood before the grant cycle; a drop in
  // that very cycle belongs to the next packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drops <= '0;
    end else if (w_grant_take) begin
      r_drops <= {15'd0, w_drop};
    end else if (w_drop) begin
      r_drops <= sat_inc16(r_drops);
    end
  end

  // ---- request timer ----
  // Runs only in IDLE while something is pending; holds during a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_grant_take || (r_level == '0 && r_drops == '0)) begin
      r_timer <= '0;
    end else if (r_state == S_IDLE) begin
      r_timer <= sat_inc_tmr(r_timer);
    end
  end

  // The request register loads one edge after the compare, so triggering at
  // TIMEOUT-1 puts daq_req high exactly TIMEOUT cycles after the capture.
  assign w_timeout = (r_timer >= TW'(TO_TRIG));

  assign w_n_grant = (r_level > LW'(MAX_EVENTS)) ? 8'(MAX_EVENTS) : 8'(r_level);

  // ---- packet FSM: next state and next registered outputs ----
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_valid_nxt  = 1'b0;
    w_end_nxt    = 1'b0;
    w_data_nxt   = r_data;
    w_n_nxt      = r_n;
    w_rem_nxt    = r_rem;
    w_grant_take = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level >= LW'(BURST) || w_timeout) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      S_REQ: begin
        w_req_nxt = 1'b1;
        if (daq_grant) begin
          w_grant_take = 1'b1;
          w_req_nxt    = 1'b0;
          w_n_nxt      = w_n_grant;
          w_valid_nxt  = 1'b1;
          w_end_nxt    = (w_n_grant == 8'd0);
          w_data_nxt   = {TAG, w_n_grant, r_drops};
          w_state_nxt  = S_HDR;
        end
      end
      S_HDR: begin
        // Header is on the bus now; fetch the first event for the next cycle.
        if (r_n == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pop       = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_rd_word;
          w_end_nxt   = (r_n == 8'd1);
          w_rem_nxt   = r_n - 8'd1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // r_rem counts events still to be fetched after the one on the bus.
        if (r_rem == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pop       = 1'b1;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_rd_word;
          w_end_nxt   = (r_rem == 8'd1);
          w_rem_nxt   = r_rem - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // ---- packet FSM: state and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_data  <= '0;
      r_n     <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_valid <= w_valid_nxt;
      r_end   <= w_end_nxt;
      r_data  <= w_data_nxt;
      r_n     <= w_n_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign daq_req   = r_req;
  assign daq_valid = r_valid;
  assign daq_end   = r_end;
  assign daq_data  = r_data;

endmodule

// File: tb/tb_daq_edge_src.sv
module tb_daq_edge_src;
  localparam int NCH = 4;
  localparam int TO  = 300;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     systime = 32'h5A000100;
  logic            enable;
  logic [NCH-1:0]  sig_in;
  logic            daq_req;
  logic            daq_grant;
  logic            daq_valid;
  logic            daq_end;
  logic [31:0]     daq_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pkt_w [0:127];
  logic        pkt_e [0:127];
  bit          model_on;

  daq_edge_src #(
    .NCH(NCH),
    .TAG(8'hE1),
    .FIFO_DEPTH(64),
    .BURST(16),
    .MAX_EVENTS(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .systime(systime),
    .enable(enable),
    .sig_in(sig_in),
    .daq_req(daq_req),
    .daq_grant(daq_grant),
    .daq_valid(daq_valid),
    .daq_end(daq_end),
    .daq_data(daq_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) systime <= systime + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change inputs just after an edge; the event is stored 3 edges later with
  // the systime value current before that edge, i.e. now + 2.
  task automatic toggle(input logic [NCH-1:0] mask);
    logic [31:0] ts;
    sig_in = sig_in ^ mask;
    ts = systime + 32'd2;
    if (enable && model_on) exp_q.push_back({4'd0, sig_in, ts[23:0]});
  endtask

  task automatic wait_req(input int limit, output int waited);
    waited = 0;
    while (!daq_req && waited < limit) begin
      tick();
      waited++;
    end
  endtask

  task automatic grant_pulse();
    daq_grant = 1'b1;
    tick();
    daq_grant = 1'b0;
  endtask

  task automatic get_packet(output int nw);
    nw = 0;
    while (daq_valid && nw < 128) begin
      pkt_w[nw] = daq_data;
      pkt_e[nw] = daq_end;
      nw++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (daq_req !== 1'b0) $display("FAIL reset_req: got %b want 0", daq_req); else n_pass++;
    n_total++; if (daq_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", daq_valid); else n_pass++;
    n_total++; if (daq_end !== 1'b0) $display("FAIL reset_end: got %b want 0", daq_end); else n_pass++;
    n_total++; if (daq_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", daq_data); else n_pass++;
    rst = 1'b0;
    repeat (5) tick();
    n_total++; if (daq_req !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", daq_req); else n_pass++;
  endtask

  task automatic test_burst();
    int nw; int ends; logic lastend; logic [31:0] exp; bit ok;
    for (int i = 0; i < 16; i++) begin
      toggle(4'b0001);
      repeat (10) tick();
      if (i == 14) begin
        n_total++; if (daq_req !== 1'b0) $display("FAIL burst_early_req: got %b want 0", daq_req); else n_pass++;
      end
    end
    n_total++; if (daq_req !== 1'b1) $display("FAIL burst_req: got %b want 1", daq_req); else n_pass++;
    grant_pulse();
    n_total++; if (daq_req !== 1'b0) $display("FAIL burst_req_drop: got %b want 0", daq_req); else n_pass++;
    get_packet(nw);
    n_total++; if (nw !== 17) $display("FAIL burst_words: got %0d want 17", nw); else n_pass++;
    n_total++; if (pkt_w[0] !== 32'hE1100000) $display("FAIL burst_hdr: got %h want E1100000", pkt_w[0]); else n_pass++;
    ends = 0;
    for (int i = 0; i < nw; i++) if (pkt_e[i]) ends++;
    lastend = (nw > 0) ? pkt_e[nw-1] : 1'b0;
    n_total++; if (ends !== 1 || lastend !== 1'b1) $display("FAIL burst_end: got %0d ends last=%b want 1 last=1", ends, lastend); else n_pass++;
    for (int i = 1; i < nw; i++) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
      n_total++; if (pkt_w[i] !== exp) $display("FAIL burst_ev%0d: got %h want %h", i, pkt_w[i], exp); else n_pass++;
    end
    ok = (nw == 17);
    for (int i = 2; i < nw; i++) begin
      if (pkt_w[i][23:0] <= pkt_w[i-1][23:0]) ok = 0;
      if (pkt_w[i][24] == pkt_w[i-1][24]) ok = 0;
    end
    n_total++; if (ok !== 1'b1) $display("FAIL burst_order: got %b want 1", ok); else n_pass++;
  endtask

  task automatic test_timeout();
    int nw; logic [31:0] exp;
    toggle(4'b0001);
    repeat (TO + 2) tick();
    n_total++; if (daq_req !== 1'b0) $display("FAIL tmo_early: got %b want 0", daq_req); else n_pass++;
    tick();
    n_total++; if (daq_req !== 1'b1) $display("FAIL tmo_req: got %b want 1", daq_req); else n_pass++;
    grant_pulse();
    get_packet(nw);
    n_total++; if (nw !== 2) $display("FAIL tmo_words: got %0d want 2", nw); else n_pass++;
    n_total++; if (pkt_w[0] !== 32'hE1010000) $display("FAIL tmo_hdr: got %h want E1010000", pkt_w[0]); else n_pass++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
    n_total++; if (pkt_w[1] !== exp) $display("FAIL tmo_ev: got %h want %h", pkt_w[1], exp); else n_pass++;
  endtask

  task automatic test_overflow();
    int nw; int w; logic [31:0] exp;
    for (int i = 0; i < 70; i++) begin
      model_on = (i < 64);
      toggle(4'b0001);
      tick();
      tick();
    end
    model_on = 1'b1;
    repeat (5) tick();
    n_total++; if (daq_req !== 1'b1) $display("FAIL ovf_req: got %b want 1", daq_req); else n_pass++;
    for (int p = 0; p < 2; p++) begin
      wait_req(10, w);
      grant_pulse();
      get_packet(nw);
      n_total++; if (nw !== 33) $display("FAIL ovf_words%0d: got %0d want 33", p, nw); else n_pass++;
      exp = (p == 0) ? 32'hE1200006 : 32'hE1200000;
      n_total++; if (pkt_w[0] !== exp) $display("FAIL ovf_hdr%0d: got %h want %h", p, pkt_w[0], exp); else n_pass++;
      for (int i = 1; i < nw; i++) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
        n_total++; if (pkt_w[i] !== exp) $display("FAIL ovf_ev%0d_%0d: got %h want %h", p, i, pkt_w[i], exp); else n_pass++;
      end
    end
    n_total++; if (exp_q.size() !== 0) $display("FAIL ovf_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int nw; int w; logic [31:0] exp;
    enable = 1'b0;
    sig_in = '0;
    repeat (6) tick();
    enable = 1'b1;
    repeat (4) tick();
    toggle(4'b0101);
    wait_req(TO + 20, w);
    n_total++; if (daq_req !== 1'b1) $display("FAIL sim_req: got %b want 1", daq_req); else n_pass++;
    grant_pulse();
    get_packet(nw);
    n_total++; if (nw !== 2) $display("FAIL sim_words: got %0d want 2", nw); else n_pass++;
    n_total++; if (pkt_w[0] !== 32'hE1010000) $display("FAIL sim_hdr: got %h want E1010000", pkt_w[0]); else n_pass++;
    n_total++; if (pkt_w[1][31:24] !== 8'h05) $display("FAIL sim_state: got %h want 05", pkt_w[1][31:24]); else n_pass++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
    n_total++; if (pkt_w[1] !== exp) $display("FAIL sim_ev: got %h want %h", pkt_w[1], exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nw; int w; logic [31:0] exp;
    for (int i = 0; i < 64; i++) begin
      toggle(4'b0010);
      tick();
      tick();
    end
    repeat (5) tick();
    n_total++; if (daq_req !== 1'b1) $display("FAIL b2b_req: got %b want 1", daq_req); else n_pass++;
    // Changes every cycle, timed so each push lands on a pop of the full FIFO.
    toggle(4'b0010);
    tick();
    toggle(4'b0010);
    daq_grant = 1'b1;
    tick();
    daq_grant = 1'b0;
    nw = 0;
    for (int j = 0; j < 40; j++) begin
      if (daq_valid) begin
        pkt_w[nw] = daq_data;
        pkt_e[nw] = daq_end;
        nw++;
      end
      if (j < 30) toggle(4'b0010);
      tick();
    end
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        wait_req(10, w);
        grant_pulse();
        get_packet(nw);
      end
      n_total++; if (nw !== 33) $display("FAIL b2b_words%0d: got %0d want 33", p, nw); else n_pass++;
      n_total++; if (pkt_w[0] !== 32'hE1200000) $display("FAIL b2b_hdr%0d: got %h want E1200000", p, pkt_w[0]); else n_pass++;
      n_total++; if (pkt_e[32] !== 1'b1) $display("FAIL b2b_end%0d: got %b want 1", p, pkt_e[32]); else n_pass++;
      for (int i = 1; i < nw; i++) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
        n_total++; if (pkt_w[i] !== exp) $display("FAIL b2b_ev%0d_%0d: got %h want %h", p, i, pkt_w[i], exp); else n_pass++;
      end
    end
    n_total++; if (exp_q.size() !== 0) $display("FAIL b2b_left: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_in_data();
    int nw; int w; logic [31:0] exp;
    enable = 1'b0;
    sig_in = '0;
    repeat (6) tick();
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      toggle(4'b0001);
      tick();
      tick();
    end
    repeat (5) tick();
    wait_req(10, w);
    grant_pulse();
    tick();
    tick();
    n_total++; if (daq_valid !== 1'b1) $display("FAIL rsd_in_data: got %b want 1", daq_valid); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (daq_req !== 1'b0) $display("FAIL rsd_req: got %b want 0", daq_req); else n_pass++;
    n_total++; if (daq_valid !== 1'b0) $display("FAIL rsd_valid: got %b want 0", daq_valid); else n_pass++;
    n_total++; if (daq_end !== 1'b0) $display("FAIL rsd_end: got %b want 0", daq_end); else n_pass++;
    n_total++; if (daq_data !== 32'h0) $display("FAIL rsd_data: got %h want 00000000", daq_data); else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    repeat (TO + 20) tick();
    n_total++; if (daq_req !== 1'b0) $display("FAIL rsd_no_req: got %b want 0", daq_req); else n_pass++;
    toggle(4'b0001);
    wait_req(TO + 20, w);
    grant_pulse();
    get_packet(nw);
    n_total++; if (nw !== 2) $display("FAIL rsd_words: got %0d want 2", nw); else n_pass++;
    n_total++; if (pkt_w[0] !== 32'hE1010000) $display("FAIL rsd_hdr: got %h want E1010000", pkt_w[0]); else n_pass++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADDEAD;
    n_total++; if (pkt_w[1] !== exp) $display("FAIL rsd_ev: got %h want %h", pkt_w[1], exp); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    sig_in    = '0;
    daq_grant = 1'b0;
    model_on  = 1'b1;
    test_reset();
    test_burst();
    test_timeout();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_in_data();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
    $fatal(1);
  end

endmodule
